// File: rtl/shift_seq_if.sv
// rtl/shift_seq_if.sv - operand/result handshake bundle for shift_seq
interface shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [AW-1:0]    amt;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             carry;

  modport master (
    output in_valid, din, amt, mode, out_ready,
    input  in_ready, out_valid, dout, carry
  );

  modport slave (
    input  in_valid, din, amt, mode, out_ready,
    output in_ready, out_valid, dout, carry
  );
endinterface

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - one-bit-per-clock shifter (LSL/LSR/ASR/ROL) with carry out
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst,
  shift_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [1:0]       mode_q, mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.din;
          mode_d  = bus.mode;
          count_d = bus.amt;
          carry_d = 1'b0;
          state_d = (bus.amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Carry always captures the bit that leaves the register on this step.
        unique case (mode_q)
          M_LSL: begin
            carry_d = data_q[WIDTH-1];
            data_d  = {data_q[WIDTH-2:0], 1'b0};
          end
          M_LSR: begin
            carry_d = data_q[0];
            data_d  = {1'b0, data_q[WIDTH-1:1]};
          end
          M_ASR: begin
            carry_d = data_q[0];
            data_d  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          end
          default: begin
            carry_d = data_q[WIDTH-1];
            data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          end
        endcase
        count_d = count_q - AW'(1);
        if (count_q == AW'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.dout      = data_q;
  assign bus.carry     = carry_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - randomized and directed checks of shift_seq against an arithmetic model
module tb_shift_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  shift_seq_if #(.WIDTH(8)) b8 ();
  shift_seq_if #(.WIDTH(4)) b4 ();

  shift_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  shift_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Net effect of a k-position shift computed directly from the operand.
  function automatic void model(input int w, input logic [31:0] d, input int k,
                                input logic [1:0] m, output logic [31:0] od, output logic oc);
    logic [31:0] mask, ext;
    logic [63:0] t;
    mask = (32'd1 << w) - 32'd1;
    if (k == 0) begin
      od = d & mask;
      oc = 1'b0;
      return;
    end
    case (m)
      2'b00: begin t = 64'(d) << k; od = t[31:0] & mask; oc = t[w]; end
      2'b01: begin od = d >> k; oc = d[k-1]; end
      2'b10: begin
        ext = d[w-1] ? (d | ~mask) : d;
        od  = 32'($signed(ext) >>> k) & mask;
        oc  = d[k-1];
      end
      default: begin od = ((d << k) | (d >> (w - k))) & mask; oc = od[0]; end
    endcase
  endfunction

  task automatic run8(input logic [1:0] m, input logic [7:0] d, input int k, input int hold);
    logic [31:0] ed;
    logic        ec;
    int          n;
    model(8, 32'(d), k, m, ed, ec);
    @(negedge clk);
    check("in_ready_idle", 32'(b8.in_ready), 32'd1);
    b8.in_valid = 1'b1; b8.din = d; b8.amt = 3'(k); b8.mode = m; b8.out_ready = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (b8.out_valid) break;
      if (n == 1) check("in_ready_busy", 32'(b8.in_ready), 32'd0);
      b8.din = 8'($urandom); b8.amt = 3'($urandom); b8.mode = 2'($urandom);
    end
    check("latency", 32'(n), 32'(k + 1));
    check("dout", 32'(b8.dout), ed);
    check("carry", 32'(b8.carry), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      b8.din = 8'($urandom); b8.amt = 3'($urandom); b8.mode = 2'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(b8.out_valid), 32'd1);
      check("hold_dout", 32'(b8.dout), ed);
      check("hold_carry", 32'(b8.carry), 32'(ec));
      check("hold_in_ready", 32'(b8.in_ready), 32'd0);
    end
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    @(negedge clk);
    check("ret_out_valid", 32'(b8.out_valid), 32'd0);
    check("ret_in_ready", 32'(b8.in_ready), 32'd1);
    b8.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ed;
    logic        ec;
    int          n;
    int          ks[2];
    b8.in_valid = 0; b8.din = 0; b8.amt = 0; b8.mode = 0; b8.out_ready = 0;
    b4.in_valid = 0; b4.din = 0; b4.amt = 0; b4.mode = 0; b4.out_ready = 0;
    #2;
    check("rst_in_ready", 32'(b8.in_ready), 32'd0);
    check("rst_out_valid", 32'(b8.out_valid), 32'd0);
    check("rst_dout", 32'(b8.dout), 32'd0);
    check("rst_carry", 32'(b8.carry), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(b8.in_ready), 32'd1);

    run8(2'b00, 8'hB3, 3, 0);
    run8(2'b01, 8'hB3, 2, 0);
    run8(2'b10, 8'hB3, 4, 0);
    run8(2'b11, 8'hB3, 1, 0);
    for (int m = 0; m < 4; m++) run8(2'(m), 8'h5A, 0, 0);
    run8(2'b11, 8'hC5, 5, 5);

    // Reset lands after three shifts of a seven-step LSL.
    @(negedge clk);
    b8.in_valid = 1'b1; b8.din = 8'hFF; b8.amt = 3'd7; b8.mode = 2'b00;
    repeat (4) @(negedge clk);
    b8.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(b8.out_valid), 32'd0);
    check("mid_rst_dout", 32'(b8.dout), 32'd0);
    check("mid_rst_carry", 32'(b8.carry), 32'd0);
    check("mid_rst_in_ready", 32'(b8.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_in_ready", 32'(b8.in_ready), 32'd1);
    run8(2'b01, 8'h80, 7, 0);

    for (int i = 0; i < 40; i++)
      run8(2'($urandom), 8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

    // WIDTH=4 back-to-back with out_ready tied high.
    ks[0] = 1; ks[1] = 3;
    b4.out_ready = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      model(4, 32'h9, ks[j], 2'b00, ed, ec);
      check("w4_in_ready", 32'(b4.in_ready), 32'd1);
      b4.in_valid = 1'b1; b4.din = 4'b1001; b4.amt = 2'(ks[j]); b4.mode = 2'b00;
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (j == 1) b4.in_valid = 1'b0;
        if (b4.out_valid) begin
          check("w4_latency", 32'(n), 32'(ks[j] + 1));
          check("w4_dout", 32'(b4.dout), ed);
          check("w4_carry", 32'(b4.carry), 32'(ec));
        end
        if (b4.in_ready) break;
      end
      check("w4_interval", 32'(n), 32'(ks[j] + 2));
    end
    b4.in_valid = 1'b0;
    @(negedge clk);
    check("w4_idle_out_valid", 32'(b4.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
